register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register and data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning register address width; register count is 2^ADDR_W (32).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-005 The block SHALL have port rs_addr, input, ADDR_W, read port A address (instruction rs field).
REQ-006 The block SHALL have port rt_addr, input, ADDR_W, read port B address (instruction rt field).
REQ-007 The block SHALL have port wr_addr, input, ADDR_W, write address (output of the 5-bit RegDst destination mux).
REQ-008 The block SHALL have port wr_data, input, DATA_W, write-back data.
REQ-009 The block SHALL have port reg_write, input, 1, write enable from control.
REQ-010 The block SHALL have port rs_data, output, DATA_W, read port A data.
REQ-011 The block SHALL have port rt_data, output, DATA_W, read port B data.

Function
REQ-012 Storage SHALL be 2^ADDR_W registers of DATA_W bits, indexed 0..31.
REQ-013 Write SHALL occur on rising clk when reg_write=1, rst_n=1 and wr_addr!=0: reg[wr_addr] <= wr_data; write latency 1 edge.
REQ-014 Writes with wr_addr=0 SHALL be discarded; register 0 reads 0 at all times.
REQ-015 Reads SHALL be combinational, zero latency: rs_data = reg[rs_addr], rt_data = reg[rt_addr].
REQ-016 Write-to-read bypass: when reg_write=1, wr_addr!=0 and wr_addr equals a read address, that port SHALL output wr_data in the same cycle (write-before-read semantics for the 5-stage pipeline).
REQ-017 rs_addr=rt_addr SHALL yield identical data on both ports, including during bypass.
REQ-018 reg_write=0 SHALL leave all storage unchanged regardless of wr_addr/wr_data.
REQ-019 One write per cycle; a same-address write in consecutive cycles SHALL leave the latest value.
REQ-020 Outputs SHALL never be X after reset for any in-range address.

Reset
REQ-021 rst_n=0 SHALL immediately (asynchronously) clear all registers to 0; rs_data/rt_data read 0 while rst_n=0 and bypass is suppressed.
REQ-022 A write coinciding with rst_n=0 SHALL be ignored; reset mid-stream discards all prior contents.
REQ-023 After rst_n deasserts, the first write SHALL take effect on the first rising clk with rst_n=1.

Structure
REQ-024 DATA_W, ADDR_W, REG_COUNT and ZERO_REG (5'd0) SHALL live in the shared processor package used by the mux and datapath.
REQ-025 The block SHALL be a single module; no sub-module (read muxing and bypass are inline).
REQ-026 Bypass compare logic SHALL be duplicated per read port, not shared.

Verification
REQ-027 Reset: rst_n=0 mid-run after writes -> all 32 registers read 0 on both ports immediately, before any clk edge.
REQ-028 Basic write/read: reg_write=1, wr_addr=12, wr_data=32'hDEADBEEF, edge; then rs_addr=12 -> rs_data=32'hDEADBEEF.
REQ-029 Zero register: reg_write=1, wr_addr=0, wr_data=32'hFFFFFFFF, edge; rs_addr=0, rt_addr=0 -> both 0.
REQ-030 Bypass: reg[25]=5; same cycle reg_write=1, wr_addr=25, wr_data=99, rs_addr=rt_addr=25 -> both ports 99 before the edge; 99 persists after it.
REQ-031 Write disable: reg_write=0, wr_addr=1, wr_data=7, edge -> reg[1] unchanged (0 after reset); walk all 31 addresses with distinct data, read back on both ports -> all match.

Source files
------------

// File: rtl/register_file_pkg.sv
`default_nettype none
// ============================================================================
// register_file_pkg : shared processor constants for the register file,
//                     destination mux and datapath.  Rev 1.0
// ============================================================================
package register_file_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int REG_COUNT = 1 << ADDR_W;

  localparam logic [4:0] ZERO_REG = 5'd0;

endpackage : register_file_pkg
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// register_file : 2-read / 1-write GPR file, r0 hard-wired to zero,
//                 write-before-read bypass on both read ports.  Rev 1.0
// ============================================================================
module register_file #(
  parameter int DATA_W = register_file_pkg::DATA_W,
  parameter int ADDR_W = register_file_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              reg_write,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data
);

  import register_file_pkg::*;

  localparam int              NUM_REGS  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic wr_valid;
  logic rs_hit;
  logic rt_hit;

  // A write is only live outside reset and never to r0.
  assign wr_valid = reg_write && rst_n && (wr_addr != ZERO_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_valid) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Each read port owns its own bypass comparator so neither port's
  // timing depends on the other's address.
  assign rs_hit = wr_valid && (wr_addr == rs_addr);
  assign rt_hit = wr_valid && (wr_addr == rt_addr);

  always_comb begin
    rs_data = '0;
    if (!rst_n || rs_addr == ZERO_ADDR) begin
      rs_data = '0;
    end else if (rs_hit) begin
      rs_data = wr_data;
    end else begin
      rs_data = regs[rs_addr];
    end
  end

  always_comb begin
    rt_data = '0;
    if (!rst_n || rt_addr == ZERO_ADDR) begin
      rt_data = '0;
    end else if (rt_hit) begin
      rt_data = wr_data;
    end else begin
      rt_data = regs[rt_addr];
    end
  end

endmodule : register_file
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_register_file : directed + random checks of register_file against an
//                    array model of the architectural registers.  Rev 1.0
// ============================================================================
module tb_register_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rs_addr, rt_addr, wr_addr;
  logic [DW-1:0] wr_data;
  logic          reg_write;
  logic [DW-1:0] rs_data, rt_data;

  logic [DW-1:0] mem [N];
  int total = 0;
  int bad   = 0;

  register_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .wr_addr(wr_addr), .wr_data(wr_data), .reg_write(reg_write),
    .rs_data(rs_data), .rt_data(rt_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Architectural view: what a read port should return right now.
  function automatic logic [DW-1:0] expect_read(input int a);
    if (!rst_n || a == 0) return '0;
    if (reg_write && wr_addr != 0 && int'(wr_addr) == a) return wr_data;
    return mem[a];
  endfunction

  // Commit the pending write to the model, then clock the DUT.
  task automatic tick();
    if (rst_n && reg_write && wr_addr != 0) mem[wr_addr] = wr_data;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) mem[i] = '0;
  endtask

  initial begin
    rst_n = 1'b0; reg_write = 1'b0;
    rs_addr = '0; rt_addr = '0; wr_addr = '0; wr_data = '0;
    clear_model();
    #1;
    rs_addr = 5'd7; rt_addr = 5'd31;
    #1;
    chk("reset_rs", rs_data, '0);
    chk("reset_rt", rt_data, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // Basic write then read back.
    reg_write = 1'b1; wr_addr = 5'd12; wr_data = 32'hDEADBEEF;
    tick();
    reg_write = 1'b0; rs_addr = 5'd12; rt_addr = 5'd3;
    #1;
    chk("basic_rs12", rs_data, 32'hDEADBEEF);
    chk("basic_rt3", rt_data, '0);

    // r0 writes are discarded, and r0 is not bypassed.
    reg_write = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    rs_addr = 5'd0; rt_addr = 5'd0;
    #1;
    chk("zero_bypass_rs", rs_data, '0);
    tick();
    reg_write = 1'b0;
    #1;
    chk("zero_rs", rs_data, '0);
    chk("zero_rt", rt_data, '0);

    // Bypass on both ports with equal addresses.
    reg_write = 1'b1; wr_addr = 5'd25; wr_data = 32'd5;
    tick();
    wr_data = 32'd99; rs_addr = 5'd25; rt_addr = 5'd25;
    #1;
    chk("bypass_rs", rs_data, 32'd99);
    chk("bypass_rt", rt_data, 32'd99);
    tick();
    reg_write = 1'b0;
    #1;
    chk("bypass_persist_rs", rs_data, 32'd99);
    chk("bypass_persist_rt", rt_data, 32'd99);

    // Disabled write must not disturb r1.
    reg_write = 1'b0; wr_addr = 5'd1; wr_data = 32'd7;
    tick();
    rs_addr = 5'd1; rt_addr = 5'd1;
    #1;
    chk("wdis_rs1", rs_data, '0);
    chk("wdis_rt1", rt_data, '0);

    // Walk every writable register with distinct data.
    for (int a = 1; a < N; a++) begin
      reg_write = 1'b1; wr_addr = AW'(a); wr_data = 32'hA5000000 | (a * 32'h01010101);
      tick();
    end
    reg_write = 1'b0;
    for (int a = 0; a < N; a++) begin
      rs_addr = AW'(a); rt_addr = AW'(N - 1 - a);
      #1;
      chk($sformatf("walk_rs%0d", a), rs_data, expect_read(a));
      chk($sformatf("walk_rt%0d", N - 1 - a), rt_data, expect_read(N - 1 - a));
    end

    // Random traffic against the model, including consecutive same-address writes.
    for (int n = 0; n < 300; n++) begin
      reg_write = 1'($urandom_range(0, 3) != 0);
      wr_addr   = AW'($urandom_range(0, N - 1));
      wr_data   = DW'($urandom);
      rs_addr   = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, N - 1));
      rt_addr   = ($urandom_range(0, 4) == 0) ? rs_addr : AW'($urandom_range(0, N - 1));
      #1;
      chk($sformatf("rnd%0d_rs", n), rs_data, expect_read(int'(rs_addr)));
      chk($sformatf("rnd%0d_rt", n), rt_data, expect_read(int'(rt_addr)));
      tick();
    end

    // Asynchronous reset mid-cycle with a write pending: all reads 0 before any edge.
    reg_write = 1'b1; wr_addr = 5'd9; wr_data = 32'h12345678;
    #1;
    rst_n = 1'b0;
    clear_model();
    for (int a = 0; a < N; a++) begin
      rs_addr = AW'(a); rt_addr = AW'(a);
      #0.2;
      chk($sformatf("arst_rs%0d", a), rs_data, '0);
      chk($sformatf("arst_rt%0d", a), rt_data, '0);
    end
    tick();
    rst_n = 1'b1;
    reg_write = 1'b0; rs_addr = 5'd9; rt_addr = 5'd12;
    #1;
    chk("post_rst_rs9", rs_data, '0);
    chk("post_rst_rt12", rt_data, '0);

    // First write after reset lands on the first edge.
    reg_write = 1'b1; wr_addr = 5'd9; wr_data = 32'hCAFEF00D;
    tick();
    reg_write = 1'b0;
    #1;
    chk("first_wr_rs9", rs_data, 32'hCAFEF00D);
    chk("first_wr_rt12", rt_data, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_register_file
`default_nettype wire
